// File: rtl/gate_sweep_checker.sv
// Two-input gate sweep engine: drives {a,b} through 00..11, samples y after a settle time, and
// reports pass, a saturating error count and a per-vector fail map. Option: GATE_CHECK_SYNC_EN.
module gate_sweep_checker #(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       truth_tbl,
  input  logic             dut_y,
  output logic             dut_a,
  output logic             dut_b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [3:0]       fail_vec
);

  // state  | meaning
  // IDLE   | waiting for start, gate inputs held at 00
  // SETTLE | current vector applied, counting down the settle time
  // SAMPLE | compare y against the latched table, then advance or finish

`ifdef GATE_CHECK_SYNC_EN
  // Two extra cycles so the synchronizer has flushed the new vector's response.
  localparam int RELOAD = SETTLE_CYCLES + 2;
`else
  localparam int RELOAD = SETTLE_CYCLES;
`endif
  localparam int CNT_W = $clog2(RELOAD + 1);
  localparam logic [CNT_W-1:0] RELOAD_V = CNT_W'(RELOAD);
  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       vec_q;
  logic [3:0]       tbl_q;
  logic             y_cmp;
  logic             mismatch;
  logic [3:0]       fail_next;

`ifdef GATE_CHECK_SYNC_EN
  logic y_s1, y_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_s1 <= 1'b0;
      y_s2 <= 1'b0;
    end else begin
      y_s1 <= dut_y;
      y_s2 <= y_s1;
    end
  end

  assign y_cmp = y_s2;
`else
  assign y_cmp = dut_y;
`endif

  assign mismatch = y_cmp ^ tbl_q[vec_q];
  assign dut_a    = vec_q[1];
  assign dut_b    = vec_q[0];

  always_comb begin
    fail_next = fail_vec;
    if (mismatch) fail_next[vec_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      vec_q    <= 2'd0;
      tbl_q    <= 4'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      err_cnt  <= '0;
      fail_vec <= 4'd0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          vec_q <= 2'd0;
          if (start) begin
            tbl_q    <= truth_tbl;
            err_cnt  <= '0;
            fail_vec <= 4'd0;
            pass     <= 1'b0;
            busy     <= 1'b1;
            cnt_q    <= RELOAD_V;
            state_q  <= SETTLE;
          end
        end
        SETTLE: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_q <= SAMPLE;
        end
        SAMPLE: begin
          fail_vec <= fail_next;
          if (mismatch && err_cnt != ERR_MAX) err_cnt <= err_cnt + ERR_W'(1);
          if (vec_q != 2'd3) begin
            vec_q   <= vec_q + 2'd1;
            cnt_q   <= RELOAD_V;
            state_q <= SETTLE;
          end else begin
            // Pass comes from the fail map so a saturated counter cannot hide errors.
            vec_q   <= 2'd0;
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= (fail_next == 4'd0);
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Bench for gate_sweep_checker: a gate model drives dut_y, a sweep-level model predicts outputs
// every cycle, and literal expectations pin the headline results.
module tb_gate_sweep_checker;
  localparam int S = 2;
`ifdef GATE_CHECK_SYNC_EN
  localparam int PER     = S + 3;
  localparam int LAT_LIT = 20;
`else
  localparam int PER     = S + 1;
  localparam int LAT_LIT = 12;
`endif
  localparam int LAT = 4 * PER;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] truth_tbl = 4'd0;
  int         mode = 0;

  logic       a0, b0, y0, busy0, done0, pass0;
  logic [2:0] err0;
  logic [3:0] fail0;
  logic       a1, b1, y1, busy1, done1, pass1;
  logic [0:0] err1;
  logic [3:0] fail1;

  int checks = 0;
  int failures = 0;
  int n_done = 0;
  int lat;

  always #5 clk = ~clk;

  // mode: 0 NOR, 1 AND, 2 tied 0, 3 tied 1
  function automatic logic gate(input int md, input logic a, input logic b);
    case (md)
      0: return ~(a | b);
      1: return a & b;
      2: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] exp_fail(input int md, input logic [3:0] tbl);
    logic [3:0] f;
    f = 4'd0;
    for (int i = 0; i < 4; i++) begin
      logic [1:0] v;
      v = 2'(i);
      if (gate(md, v[1], v[0]) != tbl[i]) f[i] = 1'b1;
    end
    return f;
  endfunction

  assign y0 = gate(mode, a0, b0);
  assign y1 = gate(mode, a1, b1);

  gate_sweep_checker #(.SETTLE_CYCLES(S), .ERR_W(3)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .truth_tbl(truth_tbl), .dut_y(y0),
    .dut_a(a0), .dut_b(b0), .busy(busy0), .done(done0), .pass(pass0),
    .err_cnt(err0), .fail_vec(fail0)
  );

  gate_sweep_checker #(.SETTLE_CYCLES(S), .ERR_W(1)) u_dut_w1 (
    .clk(clk), .rst_n(rst_n), .start(start), .truth_tbl(truth_tbl), .dut_y(y1),
    .dut_a(a1), .dut_b(b1), .busy(busy1), .done(done1), .pass(pass1),
    .err_cnt(err1), .fail_vec(fail1)
  );

  // Sweep-level model: cycles since the accepted start, and the result computed from the whole table.
  logic       m_busy, m_done, m_pass;
  int         m_k, m_errs;
  logic [3:0] m_tbl, m_fail;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_pass <= 1'b0;
      m_k <= 0; m_errs <= 0; m_tbl <= 4'd0; m_fail <= 4'd0;
    end else begin
      m_done <= 1'b0;
      if (!m_busy) begin
        if (start) begin
          m_busy <= 1'b1; m_k <= 0; m_tbl <= truth_tbl;
          m_pass <= 1'b0; m_fail <= 4'd0; m_errs <= 0;
        end
      end else if (m_k + 1 == LAT) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_fail <= exp_fail(mode, m_tbl);
        m_errs <= $countones(exp_fail(mode, m_tbl));
        m_pass <= (exp_fail(mode, m_tbl) == 4'd0);
      end else begin
        m_k <= m_k + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_cycle();
    int v;
    if (!rst_n) return;
    v = m_busy ? m_k / PER : 0;
    chk("busy", 32'(busy0), 32'(m_busy));
    chk("done", 32'(done0), 32'(m_done));
    chk("vector", 32'({a0, b0}), 32'(v));
    chk("pass", 32'(pass0), 32'(m_pass));
    chk("busy_w1", 32'(busy1), 32'(m_busy));
    chk("done_w1", 32'(done1), 32'(m_done));
    chk("vector_w1", 32'({a1, b1}), 32'(v));
    chk("pass_w1", 32'(pass1), 32'(m_pass));
    if (!m_busy) begin
      chk("err_cnt", 32'(err0), 32'(m_errs > 7 ? 7 : m_errs));
      chk("fail_vec", 32'(fail0), 32'(m_fail));
      chk("err_cnt_w1", 32'(err1), 32'(m_errs > 1 ? 1 : m_errs));
      chk("fail_vec_w1", 32'(fail1), 32'(m_fail));
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (done0) n_done++;
    cmp_cycle();
  endtask

  task automatic sweep(input int md, input logic [3:0] tbl, output int l);
    mode = md;
    truth_tbl = tbl;
    start = 1'b1;
    tick();
    start = 1'b0;
    l = 0;
    while (!done0 && l < 100) begin
      tick();
      l++;
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy0), 0);
    chk("rst_pass", 32'(pass0), 0);
    chk("rst_err", 32'(err0), 0);
    chk("rst_fail", 32'(fail0), 0);
    chk("rst_ab", 32'({a0, b0}), 0);
    rst_n = 1'b1;
    repeat (2) tick();

    sweep(0, 4'b0001, lat);
    chk("lat_nor", lat, LAT_LIT);
    chk("nor_pass", 32'(pass0), 1);
    chk("nor_err", 32'(err0), 0);
    chk("nor_fail", 32'(fail0), 0);
    repeat (3) tick();

    sweep(2, 4'b0001, lat);
    chk("tie0_pass", 32'(pass0), 0);
    chk("tie0_err", 32'(err0), 1);
    chk("tie0_fail", 32'(fail0), 4'b0001);

    // Started in the done cycle of the previous sweep.
    sweep(1, 4'b0001, lat);
    chk("and_lat", lat, LAT_LIT);
    chk("and_err", 32'(err0), 2);
    chk("and_fail", 32'(fail0), 4'b1001);
    repeat (2) tick();

    sweep(3, 4'b0000, lat);
    chk("tie1_err_w1", 32'(err1), 1);
    chk("tie1_fail_w1", 32'(fail1), 4'b1111);
    chk("tie1_pass_w1", 32'(pass1), 0);
    chk("tie1_err", 32'(err0), 4);
    repeat (2) tick();

    // Start re-pulsed and table changed mid-sweep: both ignored.
    n_done = 0;
    mode = 0;
    truth_tbl = 4'b0001;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= LAT + 4; c++) begin
      start = (c == 5);
      if (c == 5) truth_tbl = 4'b1110;
      tick();
    end
    start = 1'b0;
    chk("single_done", n_done, 1);
    chk("repulse_pass", 32'(pass0), 1);

    // Reset mid-sweep clears everything at once and no done follows.
    n_done = 0;
    truth_tbl = 4'b0001;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    chk("pre_rst_busy", 32'(busy0), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy0), 0);
    chk("abort_ab", 32'({a0, b0}), 0);
    chk("abort_pass", 32'(pass0), 0);
    chk("abort_err", 32'(err0), 0);
    chk("abort_fail", 32'(fail0), 0);
    chk("abort_done", 32'(done0), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (LAT + 4) tick();
    chk("no_done_after_abort", n_done, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/gate_sweep_checker.md
# gate_sweep_checker

Sequential stimulus-and-check engine for the two-input logic-gate library. On `start`, it drives `{dut_a, dut_b}` through all four input vectors into an external gate under test and waits a programmable settle time per vector. It then samples `dut_y` and compares it against a 4-bit expected truth table. It sits opposite the gate modules: they take `a`,`b` and produce `y`; this block produces `a`,`b` and consumes `y`, reporting pass/fail, an error count and a per-vector fail map.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 2: cycles a vector is held before sampling; legal range ≥ 1.
- `ERR_W`, default 3: width of `err_cnt`; legal range ≥ 1.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a sweep; sampled only in IDLE.
- `truth_tbl`  in  4  expected output: bit i is the expected `y` for `{a,b}` = i (NOR = 4'b0001, AND = 4'b1000).
- `dut_y`  in  1  gate-under-test output.
- `dut_a`  out  1  gate-under-test input a (MSB of vector).
- `dut_b`  out  1  gate-under-test input b (LSB of vector).
- `busy`  out  1  high from accepted start until the sweep ends.
- `done`  out  1  one-cycle pulse at sweep end.
- `pass`  out  1  result of the last sweep; held until the next accepted start.
- `err_cnt`  out  ERR_W  mismatches in the last sweep; saturates at 2^ERR_W−1.
- `fail_vec`  out  4  bit i set if vector i mismatched.

## Operation
- Reset values: all outputs 0, state IDLE, vector index 0, latched table 0, settle counter 0.
- States: IDLE, SETTLE, SAMPLE.
- **IDLE**
  - `dut_a`/`dut_b` driven 0.
  - On `start`=1:
    - Latch `truth_tbl`.
    - Clear `err_cnt`, `fail_vec`, `pass`.
    - Set `busy`=1, vector=0, counter=SETTLE_CYCLES.
    - Go to SETTLE.
- **SETTLE**
  - `{dut_a,dut_b}` = vector (registered).
  - Counter decrements each cycle.
  - When counter = 1, go to SAMPLE.
- **SAMPLE**
  - Compare `dut_y` with latched table bit[vector].
  - On mismatch: set `fail_vec[vector]`; increment `err_cnt` unless it is saturated.
  - If vector < 3: vector+1, reload counter, go to SETTLE.
  - If vector = 3: go to IDLE; `busy`=0, `done`=1 for one cycle, `pass` = (no mismatch in all four vectors, including the final compare).
- `pass` is computed from the mismatch record, not from `err_cnt`, so saturation cannot mask failures.
- `truth_tbl` changes during a sweep have no effect.
- `start` while `busy` is ignored.
- `start` in the cycle `done` is high is accepted, because the state is already IDLE.
- `rst_n` low at any point aborts the sweep immediately (asynchronously) and restores all reset values. No `done` is issued.

## Timing
- Each vector takes SETTLE_CYCLES+1 cycles: SETTLE_CYCLES in SETTLE plus 1 in SAMPLE.
- The new vector appears on `dut_a`/`dut_b` at the edge leaving IDLE or SAMPLE.
- Latency: `done` rises 4·(SETTLE_CYCLES+1) cycles after the edge that samples `start`. That is 12 cycles at the default.
- `dut_y` is sampled at the SAMPLE edge. The gate must settle within SETTLE_CYCLES clock periods.
- `busy` is high for exactly 4·(SETTLE_CYCLES+1) cycles.

## Configuration
- Macro: `GATE_CHECK_SYNC_EN`.
- **Defined:**
  - `dut_y` passes through a 2-flop synchronizer (reset 0) before the compare.
  - The SETTLE counter reloads with SETTLE_CYCLES+2.
  - Per-vector time is SETTLE_CYCLES+3 cycles; latency is 20 cycles at the default.
- **Undefined:** `dut_y` is compared directly, with the timing given above.

## Test plan
- NOR model on `dut_y`, `truth_tbl`=4'b0001, start pulse:
  - Vectors 00,01,10,11 are seen in order.
  - `done` arrives 12 cycles later with `pass`=1, `err_cnt`=0, `fail_vec`=0000.
- `dut_y` tied 0, `truth_tbl`=4'b0001 → `pass`=0, `err_cnt`=1, `fail_vec`=0001.
- AND model, `truth_tbl`=4'b0001 → `err_cnt`=2, `fail_vec`=1001.
- `ERR_W`=1, `dut_y` tied 1, `truth_tbl`=0000 → `err_cnt`=1 (saturated), `fail_vec`=1111, `pass`=0.
- Start re-pulsed at cycle 5 of a sweep → ignored; a single `done` at cycle 12. `rst_n` low at cycle 7 → all outputs 0 immediately, no `done`.
- `GATE_CHECK_SYNC_EN` defined, NOR model, tbl 0001 → `pass`=1, `done` 20 cycles after start.
